// File: rtl/offset_cal_ctrl_10b.sv
// Foreground offset-calibration sequencer: shorts the ADC input, averages 2^AVG_LOG2
// conversions and drives the saturated correction (MID_CODE - mean) to the offset adder.
module offset_cal_ctrl_10b #(
   parameter int unsigned AVG_LOG2 = 4,
   parameter int unsigned MID_CODE = 512,
   parameter int unsigned SETTLE   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cal_start,
   input  logic        cal_abort,
   input  logic        adc_valid,
   input  logic [9:0]  adc_code,
   input  logic        osc_wr,
   input  logic [9:0]  osc_wdata,
   output logic [11:0] osc,
   output logic        cal_short,
   output logic        cal_busy,
   output logic        cal_done,
   output logic        cal_err
);

   localparam int unsigned N_SAMP  = 1 << AVG_LOG2;
   localparam int unsigned ACC_W   = 10 + AVG_LOG2;
   localparam int unsigned CNT_MAX = (SETTLE > N_SAMP) ? SETTLE : N_SAMP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(N_SAMP / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_ACCUM,
      S_COMPUTE,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [9:0]        off_q, off_d;
   logic              err_q, err_d;
   logic              short_q, short_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [ACC_W:0]    rnd_sum;
   logic [10:0]       mean;
   logic signed [12:0] diff;
   logic [9:0]        diff_sat;
   logic              diff_clip;

   // Rounded mean and saturated correction, consumed in COMPUTE.
   always_comb begin
      rnd_sum   = {1'b0, acc_q} + HALF;
      mean      = 11'(rnd_sum >> AVG_LOG2);
      diff      = $signed(13'(MID_CODE)) - $signed({2'b00, mean});
      diff_sat  = diff[9:0];
      diff_clip = 1'b0;
      if (diff > 13'sd511) begin
         diff_sat  = 10'h1FF;
         diff_clip = 1'b1;
      end else if (diff < -13'sd512) begin
         diff_sat  = 10'h200;
         diff_clip = 1'b1;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      off_d   = off_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (cal_start && !cal_abort) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               acc_d   = '0;
               err_d   = 1'b0;
            end else if (osc_wr) begin
               off_d = osc_wdata;
            end
         end
         S_SETTLE: begin
            if (cal_abort) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
               state_d = S_ACCUM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ACCUM: begin
            if (cal_abort) begin
               state_d = S_IDLE;
            end else if (adc_valid) begin
               acc_d = acc_q + ACC_W'(adc_code);
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N_SAMP - 1)) begin
                  state_d = S_COMPUTE;
               end
            end
         end
         S_COMPUTE: begin
            if (cal_abort) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               off_d   = diff_sat;
               if (diff_clip) begin
                  err_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are decoded from the next state so they register in step with it.
      short_d = (state_d == S_SETTLE) || (state_d == S_ACCUM) || (state_d == S_COMPUTE);
      busy_d  = short_d;
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         off_q   <= '0;
         err_q   <= 1'b0;
         short_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         off_q   <= off_d;
         err_q   <= err_d;
         short_q <= short_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign osc       = {{2{off_q[9]}}, off_q};
   assign cal_short = short_q;
   assign cal_busy  = busy_q;
   assign cal_done  = done_q;
   assign cal_err   = err_q;

endmodule

// File: tb/tb_offset_cal_ctrl_10b.sv
// Randomized self-checking bench for offset_cal_ctrl_10b against a cycle-indexed
// transaction model of the calibration sequence.
module tb_offset_cal_ctrl_10b;

   localparam int L     = 4;
   localparam int N     = 1 << L;
   localparam int MID   = 512;
   localparam int SET_C = 8;

   logic        clk;
   logic        rst_n;
   logic        cal_start;
   logic        cal_abort;
   logic        adc_valid;
   logic [9:0]  adc_code;
   logic        osc_wr;
   logic [9:0]  osc_wdata;
   logic [11:0] osc;
   logic        cal_short;
   logic        cal_busy;
   logic        cal_done;
   logic        cal_err;

   int n_checks = 0;
   int n_errors = 0;
   int cur_osc  = 0;
   int cur_err  = 0;

   offset_cal_ctrl_10b #(
      .AVG_LOG2 (L),
      .MID_CODE (MID),
      .SETTLE   (SET_C)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cal_start (cal_start),
      .cal_abort (cal_abort),
      .adc_valid (adc_valid),
      .adc_code  (adc_code),
      .osc_wr    (osc_wr),
      .osc_wdata (osc_wdata),
      .osc       (osc),
      .cal_short (cal_short),
      .cal_busy  (cal_busy),
      .cal_done  (cal_done),
      .cal_err   (cal_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Mean with round-half-up, correction, saturation; returns 12-bit osc value.
   function automatic int model_osc(input int sum, output int clip);
      int mean;
      int diff;
      mean = (sum + N / 2) / N;
      diff = MID - mean;
      clip = 0;
      if (diff > 511) begin
         diff = 511;
         clip = 1;
      end else if (diff < -512) begin
         diff = -512;
         clip = 1;
      end
      return diff & 'hFFF;
   endfunction

   function automatic int sext10(input int d);
      return (d >= 512) ? (d + 'hC00) : d;
   endfunction

   task automatic idle_inputs();
      cal_start = 1'b0;
      cal_abort = 1'b0;
      adc_valid = 1'b0;
      osc_wr    = 1'b0;
   endtask

   task automatic write_osc(input int d);
      @(negedge clk);
      osc_wr    = 1'b1;
      osc_wdata = 10'(d);
      @(negedge clk);
      osc_wr    = 1'b0;
      cur_osc   = sext10(d);
      check("manual_wr_osc", int'(osc), cur_osc);
   endtask

   // cmode: 0 const c0, 1 alternate c0/c1 per sample, 2 random in [c0,c1]
   // vmode: 0 valid always, 1 valid on even cycles, 2 random valid
   task automatic run_cal(input int cmode, input int c0, input int c1, input int vmode,
                          input int abort_at, input bit wr_with_start, input bit noise,
                          input int fixed_osc, input int fixed_lat);
      int  sum      = 0;
      int  nacc     = 0;
      int  t_last   = -1;
      int  abort_t  = -1;
      int  exp_new  = 0;
      int  exp_clip = 0;
      int  done_m   = -1;
      int  old_osc  = cur_osc;
      bit  finished = 1'b0;
      int  code;
      bit  v;
      bit  exp_busy;
      bit  exp_done;
      bit  post;
      @(negedge clk);
      cal_start = 1'b1;
      cal_abort = 1'b0;
      adc_valid = 1'b0;
      osc_wr    = wr_with_start;
      osc_wdata = 10'($urandom);
      for (int t = 1; t < 4000; t++) begin
         int m;
         m = t - 1;
         @(negedge clk);
         if (abort_t >= 0) begin
            check("abort_busy", int'(cal_busy), 0);
            check("abort_short", int'(cal_short), 0);
            check("abort_done", int'(cal_done), 0);
            check("abort_osc", int'(osc), old_osc);
            check("abort_err", int'(cal_err), 0);
            finished = 1'b1;
            break;
         end
         post     = (t_last >= 0) && (m >= t_last + 1);
         exp_busy = (t_last < 0) || (m <= t_last);
         exp_done = (t_last >= 0) && (m == t_last + 1);
         check("busy", int'(cal_busy), int'(exp_busy));
         check("short", int'(cal_short), int'(exp_busy));
         check("done", int'(cal_done), int'(exp_done));
         check("osc", int'(osc), post ? exp_new : old_osc);
         check("err", int'(cal_err), post ? exp_clip : 0);
         if (cal_done) done_m = m;
         if (t_last >= 0 && m == t_last + 2) begin
            finished = 1'b1;
            break;
         end
         cal_start = noise && ($urandom_range(0, 7) == 0);
         osc_wr    = noise && ($urandom_range(0, 5) == 0);
         osc_wdata = 10'($urandom);
         cal_abort = 1'b0;
         case (vmode)
            0:       v = 1'b1;
            1:       v = (t % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         code = $urandom_range(0, 1023);
         if (t > SET_C && nacc < N) begin
            case (cmode)
               0:       code = c0;
               1:       code = (nacc % 2 == 0) ? c0 : c1;
               default: code = $urandom_range(c1, c0);
            endcase
         end
         if (abort_at > 0 && nacc == abort_at) begin
            cal_abort = 1'b1;
            v         = 1'b0;
            abort_t   = t;
         end
         adc_valid = v;
         adc_code  = 10'(code);
         if (!cal_abort && v && t > SET_C && nacc < N) begin
            sum += code;
            nacc++;
            if (nacc == N) begin
               t_last  = t;
               exp_new = model_osc(sum, exp_clip);
            end
         end
      end
      idle_inputs();
      if (!finished) check("cal_timeout", 0, 1);
      if (abort_t >= 0) begin
         cur_err = 0;
         repeat (3) begin
            @(negedge clk);
            check("post_abort_done", int'(cal_done), 0);
            check("post_abort_osc", int'(osc), cur_osc);
         end
      end else begin
         cur_osc = exp_new;
         cur_err = exp_clip;
         check("latency", done_m, t_last + 1);
         if (fixed_lat >= 0) check("plan_latency", done_m, fixed_lat);
         if (fixed_osc >= 0) check("plan_osc", int'(osc), fixed_osc);
      end
   endtask

   task automatic reset_mid_accum();
      @(negedge clk);
      cal_start = 1'b1;
      @(negedge clk);
      cal_start = 1'b0;
      adc_valid = 1'b1;
      adc_code  = 10'($urandom);
      repeat (SET_C + 5) @(negedge clk);
      check("pre_reset_busy", int'(cal_busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_osc", int'(osc), 0);
      check("rst_busy", int'(cal_busy), 0);
      check("rst_short", int'(cal_short), 0);
      check("rst_done", int'(cal_done), 0);
      check("rst_err", int'(cal_err), 0);
      @(negedge clk);
      idle_inputs();
      rst_n   = 1'b1;
      cur_osc = 0;
      cur_err = 0;
      repeat (SET_C + N + 4) begin
         @(negedge clk);
         check("post_rst_done", int'(cal_done), 0);
         check("post_rst_busy", int'(cal_busy), 0);
      end
      check("post_rst_osc", int'(osc), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      adc_code  = '0;
      osc_wdata = '0;
      idle_inputs();
      repeat (3) @(negedge clk);
      check("reset_osc", int'(osc), 0);
      check("reset_busy", int'(cal_busy), 0);
      check("reset_short", int'(cal_short), 0);
      check("reset_done", int'(cal_done), 0);
      check("reset_err", int'(cal_err), 0);
      rst_n = 1'b1;

      run_cal(0, 520, 520, 0, 0, 1'b0, 1'b0, 'hFF8, 25);
      run_cal(1, 500, 501, 1, 0, 1'b0, 1'b0, 'h00B, 41);
      run_cal(0, 0, 0, 0, 0, 1'b0, 1'b0, 'h1FF, -1);
      check("sat_err_set", int'(cal_err), 1);
      run_cal(0, 1023, 1023, 0, 0, 1'b0, 1'b0, 'hE01, -1);
      check("sat_err_clear", int'(cal_err), 0);

      write_osc('h3F0);
      check("plan_wr_osc", int'(osc), 'hFF0);
      run_cal(2, 0, 1023, 0, 5, 1'b0, 1'b0, -1, -1);
      check("abort_keeps_osc", int'(osc), 'hFF0);

      // start and abort together in IDLE
      @(negedge clk);
      cal_start = 1'b1;
      cal_abort = 1'b1;
      @(negedge clk);
      idle_inputs();
      check("start_abort_busy", int'(cal_busy), 0);
      check("start_abort_short", int'(cal_short), 0);
      @(negedge clk);
      check("start_abort_idle", int'(cal_busy), 0);
      check("start_abort_osc", int'(osc), cur_osc);

      run_cal(2, 400, 600, 2, 0, 1'b1, 1'b1, -1, -1);

      for (int i = 0; i < 16; i++) begin
         int lo;
         int hi;
         int ab;
         lo = $urandom_range(0, 1023);
         hi = $urandom_range(lo, 1023);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N - 1) : 0;
         if ($urandom_range(0, 1) == 1) write_osc($urandom_range(0, 1023));
         run_cal(2, lo, hi, $urandom_range(0, 2), ab, 1'($urandom_range(0, 1)), 1'b1, -1, -1);
         check("rand_err", int'(cal_err), cur_err);
      end

      reset_mid_accum();
      run_cal(0, 530, 530, 0, 0, 1'b0, 1'b0, 'hFEE, 25);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
